// File: rtl/uart_mmio_bridge.sv
// uart_mmio_fifo: circular byte buffer with extra-MSB pointers and a combinational head.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: none internally; the caller pushes when full only alongside a pop.
module uart_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_dat = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
        end
    end

    // Storage is not reset: reset empties the FIFO through the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

// uart_mmio_bridge: CPU MMIO window onto UART TX/RX FIFOs; UART_MMIO_COUNTERS_EN adds byte counters.
// Latency: loads return on rdata one cycle after rd_en; TX bytes appear the cycle after the store.
// Backpressure: TX stores to a full FIFO are dropped; RX bytes to a full FIFO are dropped and set overrun.
module uart_mmio_bridge #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ready
);
    logic       hit;
    logic [7:0] off;
    logic       rx_rd;
    logic       tx_wr;
    logic       status_wr;

    assign hit       = (addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
    assign off       = addr[7:0];
    assign rx_rd     = rd_en && hit && (off == 8'h04);
    assign tx_wr     = wr_en && hit && (off == 8'h08);
    assign status_wr = wr_en && hit && (off == 8'h00);

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    logic       tx_empty;
    logic       tx_full;
    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head_dat;

    assign tx_pop  = !tx_empty && uart_tx_ready;
    // A full FIFO still takes a store when the UART drains a byte on the same edge.
    assign tx_push = tx_wr && (!tx_full || tx_pop);

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_push),
        .push_dat (wdata[7:0]),
        .pop      (tx_pop),
        .head_dat (tx_head_dat),
        .empty    (tx_empty),
        .full     (tx_full)
    );

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_head_dat;

    logic       rx_rdy_q;
    logic       rx_hs;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_push;
    logic       rx_pop;
    logic       ovr_set;
    logic       overrun;
    logic [7:0] rx_head_dat;

    assign uart_rx_ready = rx_rdy_q;
    assign rx_hs   = uart_rx_valid && rx_rdy_q;
    assign rx_pop  = rx_rd && !rx_empty;
    assign rx_push = rx_hs && (!rx_full || rx_pop);
    assign ovr_set = rx_hs && rx_full && !rx_pop;

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rx_push),
        .push_dat (uart_rx_data),
        .pop      (rx_pop),
        .head_dat (rx_head_dat),
        .empty    (rx_empty),
        .full     (rx_full)
    );

`ifdef UART_MMIO_COUNTERS_EN
    logic [31:0] tx_cnt;
    logic [31:0] rx_cnt;
    logic        cnt_clr;

    assign cnt_clr = wr_en && hit && (off == 8'h18);

    // Clear beats a coincident increment; rx_cnt counts dropped overrun bytes too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else if (cnt_clr) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_pop) tx_cnt <= tx_cnt + 32'd1;
            if (rx_hs)  rx_cnt <= rx_cnt + 32'd1;
        end
    end
`endif

    logic [31:0] rd_dat;

    always_comb begin
        rd_dat = '0;
        if (hit) begin
            case (off)
                8'h00:   rd_dat = {29'd0, overrun, !rx_empty, !tx_full};
                8'h04:   rd_dat = {24'd0, (rx_empty ? 8'h00 : rx_head_dat)};
`ifdef UART_MMIO_COUNTERS_EN
                8'h10:   rd_dat = tx_cnt;
                8'h14:   rd_dat = rx_cnt;
`endif
                default: rd_dat = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata    <= '0;
            overrun  <= 1'b0;
            rx_rdy_q <= 1'b0;
        end else begin
            rx_rdy_q <= 1'b1;
            if (rd_en) rdata <= rd_dat;
            if (ovr_set)
                overrun <= 1'b1;
            else if (status_wr && wdata[2])
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Randomized and directed bench for uart_mmio_bridge against a queue-based register model.
module tb_uart_mmio_bridge;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  exp_out[$];
    logic [7:0]  act_out[$];
    bit          ovr;
    logic [31:0] txc, rxc, exp_rd;

    uart_mmio_bridge #(.ADDR_W(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata), .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        rxq.delete(); txq.delete(); exp_out.delete(); act_out.delete();
        ovr = 0; txc = 0; rxc = 0; exp_rd = 0;
    endtask

    // One bus cycle: update the model from the pre-edge inputs, then cross the edge.
    task automatic step();
        bit hit, rx_pop, tx_pop, ovr_set;
        logic [7:0] off;
        int rx_n, tx_n;
        #1;
        hit  = (addr[31:8] == BASE[31:8]);
        off  = addr[7:0];
        rx_n = rxq.size();
        tx_n = txq.size();
        if (rd_en) begin
            exp_rd = '0;
            if (hit) begin
                if (off == 8'h00) exp_rd = {29'd0, ovr, rx_n != 0, tx_n < DEPTH};
                else if (off == 8'h04 && rx_n != 0) exp_rd = {24'd0, rxq[0]};
`ifdef UART_MMIO_COUNTERS_EN
                else if (off == 8'h10) exp_rd = txc;
                else if (off == 8'h14) exp_rd = rxc;
`endif
            end
        end
        if (uart_tx_valid && uart_tx_ready) act_out.push_back(uart_tx_data);
        tx_pop = uart_tx_ready && (tx_n != 0);
        if (tx_pop) begin
            exp_out.push_back(txq.pop_front());
            txc = txc + 1;
        end
        if (wr_en && hit && off == 8'h08 && (tx_n < DEPTH || tx_pop)) txq.push_back(wdata[7:0]);
        rx_pop = rd_en && hit && off == 8'h04 && rx_n != 0;
        if (rx_pop) void'(rxq.pop_front());
        ovr_set = 0;
        if (uart_rx_valid) begin
            rxc = rxc + 1;
            if (rx_n == DEPTH && !rx_pop) ovr_set = 1;
            else rxq.push_back(uart_rx_data);
        end
        if (ovr_set) ovr = 1;
        else if (wr_en && hit && off == 8'h00 && wdata[2]) ovr = 0;
        if (wr_en && hit && off == 8'h18) begin
            txc = 0;
            rxc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [7:0] off);
        addr = BASE | {24'd0, off}; rd_en = 1; step(); rd_en = 0; addr = '0;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
        addr = BASE | {24'd0, off}; wdata = d; wr_en = 1; step(); wr_en = 0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rd_en = 0; wr_en = 0; uart_rx_valid = 0; uart_tx_ready = 0; addr = '0; wdata = '0;
        #2 reset = 0;
        #3 model_clear();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 reset = 0;
        #3;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        checks++; if (uart_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b want=0", uart_tx_valid); end
        checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=0", uart_tx_data); end
        checks++; if (uart_rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b want=0", uart_rx_ready); end
        model_clear();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;
        checks++; if (uart_rx_ready !== 1'b1) begin failures++; $display("FAIL post_reset_rx_ready got=%b want=1", uart_rx_ready); end
        bus_read(8'h00);
        checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL reset_status got=%h want=00000001", rdata); end
    endtask

    task automatic test_tx_order();
        logic [7:0] want [3];
        want = '{8'h41, 8'h42, 8'h43};
        do_reset();
        uart_tx_ready = 1;
        for (int i = 0; i < 3; i++) bus_write(8'h08, {24'd0, want[i]});
        repeat (3) step();
        checks++; if (act_out.size() != 3) begin failures++; $display("FAIL tx_order_count got=%0d want=3", act_out.size()); end
        for (int i = 0; i < 3 && i < act_out.size(); i++) begin
            checks++; if (act_out[i] !== want[i]) begin failures++; $display("FAIL tx_order_byte%0d got=%h want=%h", i, act_out[i], want[i]); end
        end
        checks++; if (uart_tx_valid !== 1'b0) begin failures++; $display("FAIL tx_order_valid_drop got=%b want=0", uart_tx_valid); end
        uart_tx_ready = 0;
    endtask

    task automatic test_tx_full();
        logic [7:0] sent [9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            sent[i] = 8'($urandom);
            bus_write(8'h08, {24'd0, sent[i]});
            if (i == 7) begin
                bus_read(8'h00);
                checks++; if (rdata[0] !== 1'b0) begin failures++; $display("FAIL tx_full_status got=%h want_bit0=0", rdata); end
            end
        end
        uart_tx_ready = 1;
        repeat (12) step();
        checks++; if (act_out.size() != 8) begin failures++; $display("FAIL tx_full_drain_count got=%0d want=8", act_out.size()); end
        for (int i = 0; i < 8 && i < act_out.size(); i++) begin
            checks++; if (act_out[i] !== sent[i]) begin failures++; $display("FAIL tx_full_byte%0d got=%h want=%h", i, act_out[i], sent[i]); end
        end
        uart_tx_ready = 0;
    endtask

    task automatic test_rx_overrun();
        do_reset();
        // TX held full so STATUS bit0 reads 0 during this scenario.
        for (int i = 0; i < DEPTH; i++) bus_write(8'h08, 32'($urandom));
        for (int i = 0; i < 9; i++) begin
            uart_rx_valid = 1; uart_rx_data = 8'h10 + 8'(i); step();
        end
        uart_rx_valid = 0;
        bus_read(8'h00);
        checks++; if (rdata !== 32'h6) begin failures++; $display("FAIL rx_overrun_status got=%h want=00000006", rdata); end
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h04);
            checks++; if (rdata !== 32'h10 + 32'(i)) begin failures++; $display("FAIL rx_read%0d got=%h want=%h", i, rdata, 32'h10 + 32'(i)); end
        end
        bus_read(8'h04);
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h want=0", rdata); end
        bus_write(8'h00, 32'h4);
        bus_read(8'h00);
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rx_overrun_clear got=%h want=0", rdata); end
        uart_tx_ready = 1;
        repeat (10) step();
        uart_tx_ready = 0;
    endtask

    task automatic test_rx_full_pop_push();
        logic [7:0] old [8];
        logic [7:0] nb;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            old[i] = 8'($urandom);
            uart_rx_valid = 1; uart_rx_data = old[i]; step();
        end
        nb = 8'($urandom);
        addr = BASE | 32'h4; rd_en = 1; uart_rx_valid = 1; uart_rx_data = nb;
        step();
        rd_en = 0; uart_rx_valid = 0; addr = '0;
        checks++; if (rdata !== {24'd0, old[0]}) begin failures++; $display("FAIL full_popush_head got=%h want=%h", rdata, old[0]); end
        bus_read(8'h00);
        checks++; if (rdata !== 32'h3) begin failures++; $display("FAIL full_popush_status got=%h want=00000003", rdata); end
        for (int i = 1; i < 9; i++) begin
            bus_read(8'h04);
            checks++;
            if (rdata !== {24'd0, (i < 8) ? old[i] : nb}) begin
                failures++; $display("FAIL full_popush_read%0d got=%h want=%h", i, rdata, (i < 8) ? old[i] : nb);
            end
        end
        bus_read(8'h04);
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL full_popush_empty got=%h want=0", rdata); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [9];
        addrs = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10,
                  BASE + 32'h14, BASE + 32'h18, BASE + 32'h104, 32'h0000_0008};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            addr          = addrs[$urandom_range(0, 8)];
            rd_en         = ($urandom_range(0, 2) == 0);
            wr_en         = ($urandom_range(0, 2) == 0);
            wdata         = $urandom;
            uart_rx_valid = ($urandom_range(0, 2) == 0);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(0, 3) == 0);
            step();
            checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rand_rdata cyc=%0d got=%h want=%h", c, rdata, exp_rd); end
            checks++; if (uart_tx_valid !== (txq.size() != 0)) begin failures++; $display("FAIL rand_tx_valid cyc=%0d got=%b want=%b", c, uart_tx_valid, txq.size() != 0); end
            checks++;
            if (uart_tx_data !== ((txq.size() != 0) ? txq[0] : 8'h00)) begin
                failures++; $display("FAIL rand_tx_data cyc=%0d got=%h want=%h", c, uart_tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
            end
        end
        rd_en = 0; wr_en = 0; uart_rx_valid = 0; uart_tx_ready = 1; addr = '0;
        repeat (12) step();
        checks++; if (act_out.size() != exp_out.size()) begin failures++; $display("FAIL rand_tx_count got=%0d want=%0d", act_out.size(), exp_out.size()); end
        for (int i = 0; i < act_out.size() && i < exp_out.size(); i++) begin
            checks++; if (act_out[i] !== exp_out[i]) begin failures++; $display("FAIL rand_tx_byte%0d got=%h want=%h", i, act_out[i], exp_out[i]); end
        end
        uart_tx_ready = 0;
    endtask

    task automatic test_counters();
        do_reset();
        uart_tx_ready = 1;
        for (int i = 0; i < 3; i++) bus_write(8'h08, 32'($urandom));
        for (int i = 0; i < 2; i++) begin
            uart_rx_valid = 1; uart_rx_data = 8'($urandom); step();
        end
        uart_rx_valid = 0;
        repeat (3) step();
`ifdef UART_MMIO_COUNTERS_EN
        bus_read(8'h10);
        checks++; if (rdata !== 32'd3) begin failures++; $display("FAIL tx_count got=%0d want=3", rdata); end
        bus_read(8'h14);
        checks++; if (rdata !== 32'd2) begin failures++; $display("FAIL rx_count got=%0d want=2", rdata); end
        bus_write(8'h18, 32'h0);
        bus_read(8'h10);
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL tx_count_clear got=%0d want=0", rdata); end
        bus_read(8'h14);
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rx_count_clear got=%0d want=0", rdata); end
`else
        bus_read(8'h10);
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL unmapped_0x10 got=%h want=0", rdata); end
        bus_read(8'h14);
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL unmapped_0x14 got=%h want=0", rdata); end
`endif
        uart_tx_ready = 0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) bus_write(8'h08, 32'($urandom));
        for (int i = 0; i < 3; i++) begin
            uart_rx_valid = 1; uart_rx_data = 8'($urandom); step();
        end
        uart_rx_valid = 0;
        do_reset();
        checks++; if (uart_tx_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_tx_valid got=%b want=0", uart_tx_valid); end
        bus_read(8'h00);
        checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL mid_reset_status got=%h want=00000001", rdata); end
        bus_read(8'h04);
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_reset_rx got=%h want=0", rdata); end
        uart_tx_ready = 1;
        repeat (4) step();
        checks++; if (act_out.size() != 0) begin failures++; $display("FAIL mid_reset_tx_drain got=%0d want=0", act_out.size()); end
        uart_tx_ready = 0;
    endtask

    initial begin
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_overrun();
        test_rx_full_pop_push();
        test_counters();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
CPU-facing memory-mapped controller sitting between the pipeline's data-memory port and the uart block. It decodes loads and stores in a fixed address window. It buffers transmit bytes in a TX FIFO that feeds the UART's data_in ready/valid port, and buffers bytes from the UART's data_out port in an RX FIFO. It exposes status, data and sticky overrun state to software.

Parameters:
BASE_ADDR, 32'h8000_0000, window base; decode hit when addr[31:8] == BASE_ADDR[31:8]
FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2
ADDR_W, 32, CPU address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_W  CPU byte address
rd_en  in  1  load strobe, one cycle per access
wr_en  in  1  store strobe, one cycle per access
wdata  in  32  store data
rdata  out  32  load data, registered
uart_tx_data  out  8  byte to UART transmitter (data_in)
uart_tx_valid  out  1  TX FIFO non-empty
uart_tx_ready  in  1  UART transmitter accepts byte
uart_rx_data  in  8  byte from UART receiver (data_out)
uart_rx_valid  in  1  receiver has byte
uart_rx_ready  out  1  bridge accepts byte

Behaviour:
- Reset (reset low, asynchronous): both FIFOs empty, pointers 0, overrun 0, rdata 0, uart_tx_valid 0, uart_tx_data 0, uart_rx_ready 0. Both FIFOs resume normal operation on the first clk after deassertion. A reset in the middle of a transfer discards all buffered bytes.
- Register map (offset from BASE_ADDR):
  - 0x00 STATUS (R):
    - bit0 tx_ready = TX FIFO not full
    - bit1 rx_valid = RX FIFO not empty
    - bit2 overrun (sticky)
    - bits[31:3] = 0
  - 0x00 STATUS (W): writing 1 to wdata[2] clears overrun. Other bits are ignored.
  - 0x04 RX_DATA (R): returns {24'b0, head byte} and pops. If the RX FIFO is empty, returns 0 and does not pop.
  - 0x08 TX_DATA (W): pushes wdata[7:0]. If the TX FIFO is full, the write is silently dropped.
  - Unmapped offsets and window misses: reads return 0, writes have no effect.
- Read latency is 1 cycle. rdata is updated on the clk edge after rd_en and holds until the next rd_en. STATUS reflects state before any same-cycle push or pop.
- rd_en and wr_en asserted together: both are performed.
- RX side:
  - uart_rx_ready = 1 whenever out of reset.
  - Push when uart_rx_valid && uart_rx_ready.
  - Push while full with no same-cycle pop: byte dropped, overrun set.
  - Push and CPU pop in the same cycle while full: both occur, count stays FIFO_DEPTH, no overrun.
  - Push while empty with a same-cycle RX_DATA read: read returns 0, byte is stored.
  - Overrun set and clear in the same cycle: set wins.
- TX side:
  - uart_tx_valid = TX FIFO not empty.
  - uart_tx_data = head entry, combinational from the FIFO; 0 when empty.
  - Pop on uart_tx_valid && uart_tx_ready.
  - CPU push and UART pop in the same cycle are both honoured, including when the FIFO is full.
  - Bytes go out strictly in write order.
- FIFO implementation: occupancy uses log2(FIFO_DEPTH)+1-bit counters or extra-MSB pointers. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: UART_MMIO_COUNTERS_EN.
- When defined, adds two 32-bit wrapping counters:
  - 0x10 TX_COUNT (R): bytes accepted by the UART (tx handshakes).
  - 0x14 RX_COUNT (R): bytes accepted from the UART, including dropped overrun bytes.
  - Any write to 0x18 clears both counters. An increment in the same cycle as a clear is lost; the counter reads 0.
  - Both counters reset to 0.
- When not defined: offsets 0x10–0x18 behave as unmapped (read 0, writes ignored), and no counter flops exist.

Test Plan:
- Reset, then read 0x00 -> rdata = 32'h0000_0001 (tx_ready=1, rx_valid=0, overrun=0); uart_tx_valid=0, uart_rx_ready=1.
- Write 0x41, 0x42, 0x43 to 0x08 with uart_tx_ready held high -> uart_tx_data shows 0x41, 0x42, 0x43 on consecutive handshakes; uart_tx_valid drops after the third byte.
- Hold uart_tx_ready=0 and write 9 bytes (FIFO_DEPTH=8) -> STATUS bit0=0 after the 8th write; the 9th byte is dropped; releasing ready drains exactly the 8 bytes in order.
- Drive 8 RX bytes 0x10..0x17, then a 9th byte 0x18 -> STATUS = 32'h0000_0006. Eight reads of 0x04 return 0x10..0x17; the next read returns 0. Writing 32'h4 to 0x00 makes STATUS read 0.
- RX FIFO full, with an RX_DATA read and an RX push in the same cycle -> read returns the old head; overrun stays 0; occupancy stays 8.
- With UART_MMIO_COUNTERS_EN: send 3 TX bytes and receive 2 RX bytes -> 0x10 reads 3, 0x14 reads 2; a write to 0x18 makes both read 0. Without the macro, 0x10 reads 0.
